// File: rtl/traffic_ctrl_pkg.sv
// Shared types, default durations and the demand-driven phase selection
// for the multi-approach traffic-light controller.
package traffic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } tlc_state_e;

  localparam int MAX_NCH      = 8;
  localparam int DEF_GREEN_T  = 10;
  localparam int DEF_GREEN_FM = 4;
  localparam int DEF_YLW_T    = 3;
  localparam int DEF_ALLRED_T = 1;
  localparam int DEF_PRESCALE = 16;

  // First requesting approach after phase (cyclic, phase itself last);
  // falls back to plain round-robin when nobody is requesting.
  function automatic logic [2:0] next_phase(input logic [2:0] phase,
                                            input logic [7:0] req,
                                            input int unsigned nch);
    logic [2:0]  res;
    logic [2:0]  idx3;
    logic        found;
    int unsigned p;
    p     = 32'(phase);
    res   = 3'((p + 32'd1) % nch);
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_NCH; k++) begin
      if ((k <= nch) && !found) begin
        idx3 = 3'((p + k) % nch);
        if (req[idx3]) begin
          res   = idx3;
          found = 1'b1;
        end else begin
          found = 1'b0;
        end
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Tick generator: divides the clock by PRESCALE, or ticks every cycle
// while test is high (counter parked at zero so it restarts cleanly).
module tlc_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test,
  output logic tick
);

  localparam int PCW = $clog2(PRESCALE);

  logic [PCW-1:0] pre_r;
  logic           wrap_s;

  assign wrap_s = (pre_r == PCW'(PRESCALE - 1));
  assign tick   = test | wrap_s;

  // Prescaler counter, held at zero in test mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
    end else if (test) begin
      pre_r <= '0;
    end else if (wrap_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PCW'(1);
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin multi-approach traffic-light controller with demand-driven
// phase skipping; lamps are registered from the next-state decode.
module traffic_ctrl_multi
  import traffic_ctrl_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int TW         = 8,
  parameter int GREEN_T    = DEF_GREEN_T,
  parameter int GREEN_FM_T = DEF_GREEN_FM,
  parameter int YLW_T      = DEF_YLW_T,
  parameter int ALLRED_T   = DEF_ALLRED_T,
  parameter int PRESCALE   = DEF_PRESCALE
) (
  input  logic                   CK,
  input  logic                   CLRN,
  input  logic                   FM,
  input  logic                   TEST,
  input  logic [NCH-1:0]         REQ,
  output logic [NCH-1:0]         GRN,
  output logic [NCH-1:0]         YLW,
  output logic [NCH-1:0]         RED,
  output logic [$clog2(NCH)-1:0] PHASE
);

  localparam int PW = $clog2(NCH);
  localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] GREENF_LD = TW'(GREEN_FM_T - 1);
  localparam logic [TW-1:0] YLW_LD    = TW'(YLW_T - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_T - 1);

  tlc_state_e     state_r, state_nx_s;
  logic [TW-1:0]  tmr_r, tmr_nx_s;
  logic [PW-1:0]  phase_r, phase_nx_s;
  logic [NCH-1:0] grn_r, ylw_r, red_r;
  logic [NCH-1:0] grn_nx_s, ylw_nx_s, onehot_s;
  logic [7:0]     req_ext_s;
  logic           tick_s;

  tlc_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (CK),
    .rst_n (CLRN),
    .test  (TEST),
    .tick  (tick_s)
  );

  // Next state, timer reload and phase selection, then lamp decode
  always_comb begin
    state_nx_s = state_r;
    tmr_nx_s   = tmr_r;
    phase_nx_s = phase_r;
    req_ext_s  = 8'd0;
    req_ext_s[NCH-1:0] = REQ;
    if (tick_s) begin
      if (tmr_r != TW'(0)) begin
        tmr_nx_s = tmr_r - TW'(1);
      end else begin
        case (state_r)
          ST_ALLRED: begin
            state_nx_s = ST_GREEN;
            phase_nx_s = PW'(next_phase(3'(phase_r), req_ext_s, NCH));
            tmr_nx_s   = FM ? GREENF_LD : GREEN_LD;
          end
          ST_GREEN: begin
            state_nx_s = ST_YELLOW;
            tmr_nx_s   = YLW_LD;
          end
          ST_YELLOW: begin
            state_nx_s = ST_ALLRED;
            tmr_nx_s   = ALLRED_LD;
          end
          default: begin
            state_nx_s = ST_ALLRED;
            tmr_nx_s   = ALLRED_LD;
          end
        endcase
      end
    end else begin
      tmr_nx_s = tmr_r;
    end

    onehot_s = '0;
    onehot_s[phase_nx_s] = 1'b1;
    grn_nx_s = '0;
    ylw_nx_s = '0;
    case (state_nx_s)
      ST_GREEN:  grn_nx_s = onehot_s;
      ST_YELLOW: ylw_nx_s = onehot_s;
      ST_ALLRED: grn_nx_s = '0;
      default:   grn_nx_s = '0;
    endcase
  end

  // State, timer, phase and lamp registers
  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      state_r <= ST_ALLRED;
      tmr_r   <= ALLRED_LD;
      phase_r <= PW'(NCH - 1);
      grn_r   <= '0;
      ylw_r   <= '0;
      red_r   <= '1;
    end else begin
      state_r <= state_nx_s;
      tmr_r   <= tmr_nx_s;
      phase_r <= phase_nx_s;
      grn_r   <= grn_nx_s;
      ylw_r   <= ylw_nx_s;
      red_r   <= ~(grn_nx_s | ylw_nx_s);
    end
  end

  assign GRN   = grn_r;
  assign YLW   = ylw_r;
  assign RED   = red_r;
  assign PHASE = phase_r;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-approach instance driven from a
// segment table, a 4-approach instance for demand skipping, plus random runs.
module tb_traffic_ctrl_multi;

  logic       CK = 1'b0;
  logic       CLRN = 1'b0;
  logic       FM = 1'b0;
  logic       TEST = 1'b1;
  logic [1:0] REQ = 2'b00;
  logic [1:0] GRN, YLW, RED;
  logic       PHASE;
  logic [3:0] REQ4 = 4'b0000;
  logic [3:0] GRN4, YLW4, RED4;
  logic [1:0] PHASE4;

  int n_cmp = 0;
  int n_err = 0;

  traffic_ctrl_multi dut2 (
    .CK(CK), .CLRN(CLRN), .FM(FM), .TEST(TEST), .REQ(REQ),
    .GRN(GRN), .YLW(YLW), .RED(RED), .PHASE(PHASE)
  );

  traffic_ctrl_multi #(.NCH(4)) dut4 (
    .CK(CK), .CLRN(CLRN), .FM(FM), .TEST(TEST), .REQ(REQ4),
    .GRN(GRN4), .YLW(YLW4), .RED(RED4), .PHASE(PHASE4)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic       fm;
    logic [1:0] req;
    int         cyc;
    logic [1:0] grn;
    logic [1:0] ylw;
    logic [1:0] red;
    logic       phase;
  } seg_t;

  seg_t segs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    CLRN = 1'b0;
    step();
    step();
    CLRN = 1'b1;
  endtask

  task automatic check_inv(input string name, input logic [7:0] g, input logic [7:0] y,
                           input logic [7:0] r, input logic [7:0] mask, input logic prev_y);
    check({name, " at-most-one"}, 32'($countones(g | y) <= 1), 32'd1);
    check({name, " grn&ylw"}, 32'(g & y), 32'd0);
    check({name, " all-covered"}, 32'((g | y | r) & mask), 32'(mask));
    check({name, " ylw-then-grn"}, 32'(prev_y && (g != 8'd0)), 32'd0);
  endtask

  initial begin
    int k;
    int len;
    logic [3:0] e_g4, e_y4, e_r4;
    logic pv2, pv4;

    segs[0]  = '{1'b0, 2'b00, 10, 2'b01, 2'b00, 2'b10, 1'b0};
    segs[1]  = '{1'b0, 2'b00,  3, 2'b00, 2'b01, 2'b10, 1'b0};
    segs[2]  = '{1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b0};
    segs[3]  = '{1'b0, 2'b00, 10, 2'b10, 2'b00, 2'b01, 1'b1};
    segs[4]  = '{1'b0, 2'b00,  3, 2'b00, 2'b10, 2'b01, 1'b1};
    segs[5]  = '{1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b1};
    segs[6]  = '{1'b1, 2'b00,  4, 2'b01, 2'b00, 2'b10, 1'b0};
    segs[7]  = '{1'b1, 2'b00,  3, 2'b00, 2'b01, 2'b10, 1'b0};
    segs[8]  = '{1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b0};
    segs[9]  = '{1'b0, 2'b00,  5, 2'b10, 2'b00, 2'b01, 1'b1};
    segs[10] = '{1'b1, 2'b00,  5, 2'b10, 2'b00, 2'b01, 1'b1};
    segs[11] = '{1'b1, 2'b00,  3, 2'b00, 2'b10, 2'b01, 1'b1};
    segs[12] = '{1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b1};
    segs[13] = '{1'b1, 2'b00,  4, 2'b01, 2'b00, 2'b10, 1'b0};
    segs[14] = '{1'b1, 2'b01,  3, 2'b00, 2'b01, 2'b10, 1'b0};
    segs[15] = '{1'b1, 2'b01,  1, 2'b00, 2'b00, 2'b11, 1'b0};
    segs[16] = '{1'b1, 2'b01,  4, 2'b01, 2'b00, 2'b10, 1'b0};
    segs[17] = '{1'b0, 2'b10,  3, 2'b00, 2'b01, 2'b10, 1'b0};
    segs[18] = '{1'b0, 2'b10,  1, 2'b00, 2'b00, 2'b11, 1'b0};
    segs[19] = '{1'b0, 2'b10, 10, 2'b10, 2'b00, 2'b01, 1'b1};

    // Sequence 1: TEST=1 table walk on the 2-approach instance
    TEST = 1'b1; FM = 1'b0; REQ = 2'b00;
    do_reset();
    check("reset lamps", 32'({GRN, YLW, RED, PHASE}), 32'({2'b00, 2'b00, 2'b11, 1'b1}));
    for (int s = 0; s < 20; s++) begin
      FM  = segs[s].fm;
      REQ = segs[s].req;
      for (int c = 0; c < segs[s].cyc; c++) begin
        step();
        check($sformatf("seg%0d cyc%0d", s, c), 32'({GRN, YLW, RED, PHASE}),
              32'({segs[s].grn, segs[s].ylw, segs[s].red, segs[s].phase}));
      end
    end

    // Sequence 2: prescaled timing with TEST=0
    TEST = 1'b0; FM = 1'b0; REQ = 2'b00;
    do_reset();
    k = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (GRN != 2'b00) begin
        k = c;
        break;
      end
    end
    check("prescaled first green delay", 32'(k), 32'd16);
    check("prescaled first green lamp", 32'(GRN), 32'(2'b01));
    len = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (GRN != 2'b00) len++;
      else break;
    end
    check("prescaled green length", 32'(len), 32'd160);
    check("prescaled yellow lamp", 32'(YLW), 32'(2'b01));
    len = 1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (YLW != 2'b00) len++;
      else break;
    end
    check("prescaled yellow length", 32'(len), 32'd48);
    check("prescaled allred", 32'(RED), 32'(2'b11));

    // Sequence 3: reset pulse during yellow abandons the phase
    TEST = 1'b1;
    do_reset();
    k = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (YLW != 2'b00) begin
        k = 1;
        break;
      end
    end
    check("reached yellow", 32'(k), 32'd1);
    CLRN = 1'b0;
    #1;
    check("async reset lamps", 32'({GRN, YLW, RED, PHASE}), 32'({2'b00, 2'b00, 2'b11, 1'b1}));
    #2;
    CLRN = 1'b1;
    step();
    check("restart at approach 0", 32'({GRN, YLW, RED, PHASE}), 32'({2'b01, 2'b00, 2'b10, 1'b0}));

    // Sequence 4: 4-approach instance with only approach 3 requesting
    REQ4 = 4'b1000; TEST = 1'b1; FM = 1'b0;
    do_reset();
    check("nch4 reset phase", 32'(PHASE4), 32'd3);
    for (int c = 0; c < 56; c++) begin
      step();
      e_g4 = (c % 14 < 10) ? 4'b1000 : 4'b0000;
      e_y4 = (c % 14 >= 10 && c % 14 < 13) ? 4'b1000 : 4'b0000;
      e_r4 = ~(e_g4 | e_y4);
      check($sformatf("nch4 cyc%0d", c), 32'({GRN4, YLW4, RED4, PHASE4}),
            32'({e_g4, e_y4, e_r4, 2'd3}));
    end

    // Sequence 5: random demand / mode run, invariants every cycle
    REQ4 = 4'b0000;
    do_reset();
    pv2 = 1'b0;
    pv4 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      REQ  = 2'($urandom_range(0, 3));
      REQ4 = 4'($urandom_range(0, 15));
      FM   = 1'($urandom_range(0, 1));
      TEST = ($urandom_range(0, 7) != 0);
      step();
      check_inv("rand2", 8'(GRN), 8'(YLW), 8'(RED), 8'h03, pv2);
      check_inv("rand4", 8'(GRN4), 8'(YLW4), 8'(RED4), 8'h0F, pv4);
      pv2 = (YLW != 2'b00);
      pv4 = (YLW4 != 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
